// File: rtl/updi_pkg.sv
// updi_pkg: definitions shared by the UPDI link blocks.
//   tx_state_t           - transmitter FSM states
//   UPDI_SYNC            - UPDI synchronisation character
//   UPDI_BREAK_BITS_DFLT - default BREAK length in bit times
//   max_int()            - maximum of two ints, used to size counters
package updi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } tx_state_t;

  localparam logic [7:0] UPDI_SYNC            = 8'h55;
  localparam int         UPDI_BREAK_BITS_DFLT = 24;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parity.sv
// parity: combinational parity generator.
//   i_data   [BITS] - word to protect
//   o_parity [1]    - parity bit; "even" makes the total count of ones even,
//                     "odd" makes it odd, "none" drives 0
module parity #(
  parameter int    BITS   = 8,
  parameter string PARITY = "even"
) (
  input  logic [BITS-1:0] i_data,
  output logic            o_parity
);

  localparam bit IS_ODD  = (PARITY == "odd");
  localparam bit IS_EVEN = (PARITY == "even");

  // Parity selection by mode
  always_comb begin
    o_parity = 1'b0;
    if (IS_ODD) begin
      o_parity = ~(^i_data);
    end else if (IS_EVEN) begin
      o_parity = ^i_data;
    end else begin
      o_parity = 1'b0;
    end
  end

endmodule

// File: rtl/updi_uart_tx.sv
// updi_uart_tx: UPDI single-wire serial transmitter.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Also emits a BREAK (line low for BREAK_BITS bit times).
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   data    in   byte to send
//   valid   in   data is valid
//   ready   out  byte can be accepted (combinational)
//   brk_req in   request a BREAK (wins over valid)
//   tx      out  serial line, idle high
//   tx_oe   out  pad output enable
//   busy    out  frame or BREAK in progress
//   done    out  one-cycle pulse on completion
module updi_uart_tx
  import updi_pkg::*;
#(
  parameter int    CLK_DIV    = 16,
  parameter int    DATA_BITS  = 8,
  parameter string PARITY     = "even",
  parameter int    STOP_BITS  = 2,
  parameter int    BREAK_BITS = UPDI_BREAK_BITS_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  input  logic                 brk_req,
  output logic                 tx,
  output logic                 tx_oe,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_BITS = max_int(max_int(DATA_BITS, STOP_BITS), BREAK_BITS);
  localparam int BIT_W    = $clog2(MAX_BITS + 1);
  localparam bit HAS_PAR  = (PARITY != "none");

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BREAK_LAST = BIT_W'(BREAK_BITS - 1);

  tx_state_t             r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_byte;
  logic                  r_tx;
  logic                  r_tx_oe;
  logic                  r_busy;
  logic                  r_done;

  tx_state_t             w_state_nxt;
  logic [BAUD_W-1:0]     w_baud_nxt;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic [DATA_BITS-1:0]  w_shift_nxt;
  logic [DATA_BITS-1:0]  w_byte_nxt;
  logic                  w_tx_nxt;
  logic                  w_done_nxt;
  logic                  w_bit_tick;
  logic                  w_par;

  // r_byte is a separate copy because r_shift is consumed while sending,
  // and the parity bit must reflect the whole latched byte.
  parity #(
    .BITS   (DATA_BITS),
    .PARITY (PARITY)
  ) u_parity (
    .i_data   (r_byte),
    .o_parity (w_par)
  );

  assign ready      = (r_state == ST_IDLE) && !brk_req;
  assign w_bit_tick = (r_baud == BAUD_LAST);
  assign tx         = r_tx;
  assign tx_oe      = r_tx_oe;
  assign busy       = r_busy;
  assign done       = r_done;

  // Next-state, counter and datapath logic
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_tick ? {BAUD_W{1'b0}} : (r_baud + BAUD_W'(1));
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_byte_nxt  = r_byte;
    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = {BAUD_W{1'b0}};
        w_bit_nxt  = {BIT_W{1'b0}};
        if (brk_req) begin
          w_state_nxt = ST_BREAK;
        end else if (valid) begin
          w_shift_nxt = data;
          w_byte_nxt  = data;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_tick) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == DATA_LAST) begin
            w_bit_nxt   = {BIT_W{1'b0}};
            w_state_nxt = HAS_PAR ? ST_PAR : ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PAR: begin
        if (w_bit_tick) begin
          w_state_nxt = ST_STOP;
        end else begin
          w_state_nxt = ST_PAR;
        end
      end
      ST_STOP: begin
        if (w_bit_tick) begin
          if (r_bit == STOP_LAST) begin
            w_bit_nxt   = {BIT_W{1'b0}};
            w_state_nxt = ST_IDLE;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (w_bit_tick) begin
          if (r_bit == BREAK_LAST) begin
            w_bit_nxt   = {BIT_W{1'b0}};
            w_state_nxt = ST_IDLE;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_state_nxt = ST_BREAK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = {BAUD_W{1'b0}};
        w_bit_nxt   = {BIT_W{1'b0}};
      end
    endcase
  end

  // Line level is decoded from the next state so the registered tx lines up
  // with the state register (tx falls the cycle after acceptance).
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_IDLE:  w_tx_nxt = 1'b1;
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      ST_PAR:   w_tx_nxt = w_par;
      ST_STOP:  w_tx_nxt = 1'b1;
      ST_BREAK: w_tx_nxt = 1'b0;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign w_done_nxt = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= {BAUD_W{1'b0}};
      r_bit   <= {BIT_W{1'b0}};
      r_shift <= {DATA_BITS{1'b0}};
      r_byte  <= {DATA_BITS{1'b0}};
      r_tx    <= 1'b1;
      r_tx_oe <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_tx_oe <= (w_state_nxt != ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_updi_uart_tx.sv
// tb_updi_uart_tx: directed bench for updi_uart_tx.
// Four instances share clk/rst_n:
//   0: CLK_DIV=4 even, 2 stop   1: CLK_DIV=4 odd
//   2: CLK_DIV=4 none           3: CLK_DIV=2 even, 1 stop
module tb_updi_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_a    [4];
  logic       valid_a   [4];
  logic       brk_a     [4];
  logic       ready_a   [4];
  logic       tx_a      [4];
  logic       tx_oe_a   [4];
  logic       busy_a    [4];
  logic       done_a    [4];

  int n_err;
  int n_checks;

  updi_uart_tx #(.CLK_DIV(4), .PARITY("even"), .STOP_BITS(2), .BREAK_BITS(24)) u0 (
    .clk(clk), .rst_n(rst_n), .data(data_a[0]), .valid(valid_a[0]), .ready(ready_a[0]),
    .brk_req(brk_a[0]), .tx(tx_a[0]), .tx_oe(tx_oe_a[0]), .busy(busy_a[0]), .done(done_a[0]));
  updi_uart_tx #(.CLK_DIV(4), .PARITY("odd"), .STOP_BITS(2), .BREAK_BITS(24)) u1 (
    .clk(clk), .rst_n(rst_n), .data(data_a[1]), .valid(valid_a[1]), .ready(ready_a[1]),
    .brk_req(brk_a[1]), .tx(tx_a[1]), .tx_oe(tx_oe_a[1]), .busy(busy_a[1]), .done(done_a[1]));
  updi_uart_tx #(.CLK_DIV(4), .PARITY("none"), .STOP_BITS(2), .BREAK_BITS(24)) u2 (
    .clk(clk), .rst_n(rst_n), .data(data_a[2]), .valid(valid_a[2]), .ready(ready_a[2]),
    .brk_req(brk_a[2]), .tx(tx_a[2]), .tx_oe(tx_oe_a[2]), .busy(busy_a[2]), .done(done_a[2]));
  updi_uart_tx #(.CLK_DIV(2), .PARITY("even"), .STOP_BITS(1), .BREAK_BITS(24)) u3 (
    .clk(clk), .rst_n(rst_n), .data(data_a[3]), .valid(valid_a[3]), .ready(ready_a[3]),
    .brk_req(brk_a[3]), .tx(tx_a[3]), .tx_oe(tx_oe_a[3]), .busy(busy_a[3]), .done(done_a[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the instance idle. pat holds the expected line
  // levels, one per bit time, first bit in pat[0]. Returns on the negedge
  // of the done cycle. With hold=1 valid stays high and data becomes nxt.
  task automatic send(input int idx, input logic [7:0] d, input logic [15:0] pat,
                      input int nbits, input int div, input bit hold, input logic [7:0] nxt);
    data_a[idx]  = d;
    valid_a[idx] = 1'b1;
    #1;
    chk($sformatf("ready_idle[%0d]", idx), 32'(ready_a[idx]), 32'd1);
    @(posedge clk);
    #1;
    data_a[idx] = nxt;
    if (!hold) valid_a[idx] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < nbits * div; k++) begin
      chk($sformatf("tx[%0d] k=%0d", idx, k), 32'(tx_a[idx]), 32'(pat[k / div]));
      chk($sformatf("oe[%0d] k=%0d", idx, k), 32'(tx_oe_a[idx]), 32'd1);
      chk($sformatf("busy[%0d] k=%0d", idx, k), 32'(busy_a[idx]), 32'd1);
      chk($sformatf("ready_busy[%0d] k=%0d", idx, k), 32'(ready_a[idx]), 32'd0);
      chk($sformatf("done_early[%0d] k=%0d", idx, k), 32'(done_a[idx]), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("done[%0d]", idx), 32'(done_a[idx]), 32'd1);
    chk($sformatf("tx_end[%0d]", idx), 32'(tx_a[idx]), 32'd1);
    chk($sformatf("oe_end[%0d]", idx), 32'(tx_oe_a[idx]), 32'd0);
    chk($sformatf("busy_end[%0d]", idx), 32'(busy_a[idx]), 32'd0);
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_a[i]  = 8'h00;
      valid_a[i] = 1'b0;
      brk_a[i]   = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx_a[0]), 32'd1);
    chk("rst_oe", 32'(tx_oe_a[0]), 32'd0);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_done", 32'(done_a[0]), 32'd0);
    chk("rst_ready", 32'(ready_a[0]), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8'h55 even: 0, 10101010, 0, 11 (data changes mid-frame are ignored)
    send(0, 8'h55, 16'b0000_11_0_01010101_0, 12, 4, 1'b0, 8'hFF);
    @(negedge clk);
    // 8'h07 even -> parity 1
    send(0, 8'h07, 16'b0000_11_1_00000111_0, 12, 4, 1'b0, 8'h00);
    // 8'h07 odd -> parity 0
    send(1, 8'h07, 16'b0000_11_0_00000111_0, 12, 4, 1'b0, 8'hF8);
    // 8'h07 no parity -> 11 bits, 44 cycles
    send(2, 8'h07, 16'b00000_11_00000111_0, 11, 4, 1'b0, 8'h00);
    // CLK_DIV=2, 1 stop, 8'hFF even -> parity 0, 22 cycles
    send(3, 8'hFF, 16'b00000_1_0_11111111_0, 11, 2, 1'b0, 8'h00);
    @(negedge clk);

    // BREAK wins over valid; byte is taken on the IDLE cycle after done
    data_a[0]  = 8'h55;
    valid_a[0] = 1'b1;
    brk_a[0]   = 1'b1;
    #1;
    chk("ready_brk", 32'(ready_a[0]), 32'd0);
    @(negedge clk);
    brk_a[0] = 1'b0;
    for (int k = 0; k < 96; k++) begin
      chk($sformatf("brk_tx k=%0d", k), 32'(tx_a[0]), 32'd0);
      chk($sformatf("brk_oe k=%0d", k), 32'(tx_oe_a[0]), 32'd1);
      chk($sformatf("brk_ready k=%0d", k), 32'(ready_a[0]), 32'd0);
      chk($sformatf("brk_done k=%0d", k), 32'(done_a[0]), 32'd0);
      @(negedge clk);
    end
    chk("brk_done", 32'(done_a[0]), 32'd1);
    chk("brk_tx_end", 32'(tx_a[0]), 32'd1);
    send(0, 8'h55, 16'b0000_11_0_01010101_0, 12, 4, 1'b0, 8'h00);
    @(negedge clk);

    // Back-to-back: 8'hAA (parity 0) then 8'h01 (parity 1) with valid held
    send(0, 8'hAA, 16'b0000_11_0_10101010_0, 12, 4, 1'b1, 8'h01);
    send(0, 8'h01, 16'b0000_11_1_00000001_0, 12, 4, 1'b0, 8'h00);
    @(negedge clk);

    // Reset 20 cycles into a frame
    data_a[0]  = 8'h55;
    valid_a[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_a[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_oe", 32'(tx_oe_a[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx", 32'(tx_a[0]), 32'd1);
    chk("mrst_oe", 32'(tx_oe_a[0]), 32'd0);
    chk("mrst_busy", 32'(busy_a[0]), 32'd0);
    chk("mrst_done", 32'(done_a[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk($sformatf("post_done k=%0d", k), 32'(done_a[0]), 32'd0);
      chk($sformatf("post_tx k=%0d", k), 32'(tx_a[0]), 32'd1);
      chk($sformatf("post_oe k=%0d", k), 32'(tx_oe_a[0]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
